// File: rtl/onehot_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder_if
// Brief    : Valid/ready bus bundle for the one-hot decoder (index in, one-hot out).
// Revision : 1.0 - initial release
// ============================================================================
interface onehot_decoder_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
);
    localparam int IDX_WIDTH = $clog2(WIDTH);

    logic                 iValid;
    logic                 oReady;
    logic [IDX_WIDTH-1:0] iData;
    logic                 oValid;
    logic                 iReady;
    logic [WIDTH-1:0]     oData;
    logic                 oErr;
    logic [CNT_WIDTH-1:0] oErrCount;

    modport master (
        output iValid, iData, iReady,
        input  oReady, oValid, oData, oErr, oErrCount
    );

    modport slave (
        input  iValid, iData, iReady,
        output oReady, oValid, oData, oErr, oErrCount
    );
endinterface
`default_nettype wire

// File: rtl/onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Brief    : Binary index to one-hot decoder behind a two-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decoder #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic       iClk,
    input  wire logic       iRst,
    onehot_decoder_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [31:0]          w_idx;
    logic                 w_dec_err;
    logic [WIDTH-1:0]     w_dec_data;
    logic                 w_accept;
    logic                 w_out_free;
    logic                 w_skid_valid_nxt;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_err;
    logic                 r_skid_valid;
    logic [WIDTH-1:0]     r_skid_data;
    logic                 r_skid_err;
    logic                 r_ready;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    assign w_idx = 32'(bus.iData);

    always_comb begin
        w_dec_err  = (w_idx >= 32'(WIDTH));
        w_dec_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_dec_data[i] = (w_idx == 32'(i));
        end
    end

    assign w_accept   = bus.iValid && r_ready;
    assign w_out_free = !r_out_valid || bus.iReady;
    // A free output stage always absorbs the skid entry or the new beat,
    // so the skid only holds data while the output register is stalled.
    assign w_skid_valid_nxt = w_out_free ? 1'b0 : (r_skid_valid || w_accept);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
            r_ready      <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_err   <= r_skid_err;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_dec_data;
                    r_out_err   <= w_dec_err;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data <= w_dec_data;
                r_skid_err  <= w_dec_err;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= !w_skid_valid_nxt;
            if (w_accept && w_dec_err && (r_err_cnt != c_cnt_max)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.oReady    = r_ready;
    assign bus.oValid    = r_out_valid;
    assign bus.oData     = r_out_data;
    assign bus.oErr      = r_out_err;
    assign bus.oErrCount = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_decoder
// Brief    : Self-checking bench for onehot_decoder (WIDTH=32 and WIDTH=12 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_decoder;
    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    typedef struct {
        logic        v;
        int          idx;
        logic        rdy;
        logic        e_valid;
        logic        e_ready;
        logic        e_dchk;
        logic [31:0] e_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onehot_decoder_if #(.WIDTH(32), .CNT_WIDTH(8)) b32 ();
    onehot_decoder_if #(.WIDTH(12), .CNT_WIDTH(2)) b12 ();

    onehot_decoder #(.WIDTH(32), .CNT_WIDTH(8)) dut32 (.iClk(clk), .iRst(rst), .bus(b32));
    onehot_decoder #(.WIDTH(12), .CNT_WIDTH(2)) dut12 (.iClk(clk), .iRst(rst), .bus(b12));

    int    checks = 0;
    int    errors = 0;
    beat_t q0[$];
    beat_t q1[$];
    int    cnt_m[2];
    logic  prev_hold[2];
    beat_t prev_beat[2];
    vec_t  tv[11];

    logic        m_ovalid[2];
    logic        m_oready[2];
    logic        m_oerr[2];
    logic [31:0] m_odata[2];
    logic [7:0]  m_cnt[2];

    always_comb begin
        m_ovalid[0] = b32.oValid;
        m_oready[0] = b32.oReady;
        m_oerr[0]   = b32.oErr;
        m_odata[0]  = b32.oData;
        m_cnt[0]    = b32.oErrCount;
        m_ovalid[1] = b12.oValid;
        m_oready[1] = b12.oReady;
        m_oerr[1]   = b12.oErr;
        m_odata[1]  = {20'b0, b12.oData};
        m_cnt[1]    = {6'b0, b12.oErrCount};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t model(input int w, input int idx);
        beat_t b;
        b = '0;
        if (idx < w) b.d[idx] = 1'b1;
        else         b.e      = 1'b1;
        return b;
    endfunction

    // Outputs are registered, so values seen at the falling edge describe
    // what the coming rising edge will transfer.
    task automatic track(input int s, input logic rs, input logic v, input int idx, input logic rdy);
        beat_t got;
        beat_t exp;
        logic  have;
        int    w;
        int    mx;
        w  = (s == 0) ? 32 : 12;
        mx = (s == 0) ? 255 : 3;
        if (rs) begin
            if (s == 0) q0.delete(); else q1.delete();
            cnt_m[s]     = 0;
            prev_hold[s] = 1'b0;
            return;
        end
        got.d = m_odata[s];
        got.e = m_oerr[s];
        if (prev_hold[s]) chk("hold_stable", 64'(got), 64'(prev_beat[s]));
        chk("err_count", 64'(m_cnt[s]), 64'(cnt_m[s]));
        if (m_ovalid[s] && rdy) begin
            have = 1'b0;
            exp  = '0;
            if (s == 0) begin
                if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
            end else begin
                if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat dut%0d actual=0x%0h required=no_beat", s, got.d);
            end else begin
                chk("beat", 64'(got), 64'(exp));
                chk("popcount", 64'($countones(got.d)), got.e ? 64'd0 : 64'd1);
            end
        end
        if (v && m_oready[s]) begin
            exp = model(w, idx);
            if (s == 0) q0.push_back(exp); else q1.push_back(exp);
            if (exp.e && cnt_m[s] < mx) cnt_m[s]++;
        end
        prev_hold[s] = m_ovalid[s] && !rdy;
        prev_beat[s] = got;
    endtask

    task automatic tick(input int sel, input logic v, input int idx, input logic rdy, input logic rs);
        @(negedge clk);
        rst = rs;
        if (sel == 0) begin
            b32.iValid = v;    b32.iData = 5'(idx); b32.iReady = rdy;
            b12.iValid = 1'b0; b12.iData = 4'd0;    b12.iReady = 1'b1;
        end else begin
            b12.iValid = v;    b12.iData = 4'(idx); b12.iReady = rdy;
            b32.iValid = 1'b0; b32.iData = 5'd0;    b32.iReady = 1'b1;
        end
        track(0, rs, (sel == 0) ? v : 1'b0, idx, (sel == 0) ? rdy : 1'b1);
        track(1, rs, (sel == 1) ? v : 1'b0, idx, (sel == 1) ? rdy : 1'b1);
    endtask

    initial begin
        //          v     idx  rdy   e_val e_rdy e_dchk e_data
        tv[0]  = '{1'b1, 0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 5,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001};
        tv[2]  = '{1'b1, 31, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0020};
        tv[3]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0000};
        tv[4]  = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 3,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[6]  = '{1'b1, 4,  1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0008};
        tv[7]  = '{1'b1, 9,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008};
        tv[8]  = '{1'b0, 0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0008};
        tv[9]  = '{1'b0, 0,  1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010};
        tv[10] = '{1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        cnt_m     = '{0, 0};
        prev_hold = '{1'b0, 1'b0};
        prev_beat = '{'0, '0};

        for (int i = 0; i < 3; i++) tick(0, 1'b0, 0, 1'b1, 1'b1);
        chk("rst_valid32", 64'(b32.oValid), 64'd0);
        chk("rst_data32",  64'(b32.oData),  64'd0);
        chk("rst_err32",   64'(b32.oErr),   64'd0);
        chk("rst_cnt32",   64'(b32.oErrCount), 64'd0);
        chk("rst_ready32", 64'(b32.oReady), 64'd0);
        chk("rst_valid12", 64'(b12.oValid), 64'd0);
        chk("rst_ready12", 64'(b12.oReady), 64'd0);
        tick(0, 1'b0, 0, 1'b1, 1'b0);

        // Back-to-back decode, then skid fill / drain on the 32-wide build
        for (int i = 0; i < 11; i++) begin
            tick(0, tv[i].v, tv[i].idx, tv[i].rdy, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(b32.oValid), 64'(tv[i].e_valid));
            chk($sformatf("vec%0d_ready", i), 64'(b32.oReady), 64'(tv[i].e_ready));
            if (tv[i].e_dchk) begin
                chk($sformatf("vec%0d_data", i), 64'(b32.oData), 64'(tv[i].e_data));
                chk($sformatf("vec%0d_err", i),  64'(b32.oErr),  64'd0);
            end
        end

        // Out-of-range index is forwarded with oErr set
        tick(1, 1'b1, 13, 1'b1, 1'b0);
        tick(1, 1'b1, 11, 1'b1, 1'b0);
        chk("oor_valid", 64'(b12.oValid), 64'd1);
        chk("oor_data",  64'(b12.oData),  64'd0);
        chk("oor_err",   64'(b12.oErr),   64'd1);
        tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("in_data",   64'(b12.oData),  64'h800);
        chk("in_err",    64'(b12.oErr),   64'd0);
        chk("oor_cnt",   64'(b12.oErrCount), 64'd1);
        tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("idle_valid", 64'(b12.oValid), 64'd0);

        // Reset with two beats buffered
        tick(1, 1'b1, 2, 1'b0, 1'b0);
        tick(1, 1'b1, 3, 1'b0, 1'b0);
        tick(1, 1'b0, 0, 1'b0, 1'b0);
        chk("full_ready", 64'(b12.oReady), 64'd0);
        chk("full_data",  64'(b12.oData),  64'h4);
        tick(1, 1'b0, 0, 1'b0, 1'b1);
        tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("mid_rst_valid", 64'(b12.oValid),    64'd0);
        chk("mid_rst_cnt",   64'(b12.oErrCount), 64'd0);
        chk("mid_rst_ready", 64'(b12.oReady),    64'd0);
        tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("rel_ready", 64'(b12.oReady), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("no_stale", 64'(b12.oValid), 64'd0);
            tick(1, 1'b0, 0, 1'b1, 1'b0);
        end

        // Error counter saturates at 3 with CNT_WIDTH=2
        for (int i = 0; i < 5; i++) begin
            tick(1, 1'b1, 12 + (i % 4), 1'b1, 1'b0);
            chk($sformatf("sat_cnt%0d", i), 64'(b12.oErrCount), 64'((i < 3) ? i : 3));
        end
        tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("sat_cnt_final", 64'(b12.oErrCount), 64'd3);

        for (int i = 0; i < 10000; i++) begin
            tick(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 8; i++) tick(1, 1'b0, 0, 1'b1, 1'b0);
        chk("drain_q32", 64'(q0.size()), 64'd0);
        chk("drain_q12", 64'(q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 Parameter WIDTH, default 32: number of one-hot output lines; legal range 2..1024.
REQ-002 Parameter CNT_WIDTH, default 8: width of the out-of-range event counter.
REQ-003 Port iClk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port iRst, input, 1: reset, synchronous and active-high.
REQ-005 Port iValid, input, 1: upstream beat valid.
REQ-006 Port oReady, output, 1: the block can accept a beat.
REQ-007 Port iData, input, $clog2(WIDTH): binary index to decode.
REQ-008 Port oValid, output, 1: downstream beat valid.
REQ-009 Port iReady, input, 1: downstream can accept a beat.
REQ-010 Port oData, output, WIDTH: one-hot decoded value.
REQ-011 Port oErr, output, 1: per-beat flag, current oData beat came from an out-of-range index.
REQ-012 Port oErrCount, output, CNT_WIDTH: saturating count of accepted out-of-range beats.

Function
REQ-013 Input transfer when iValid && oReady on a clock edge; output transfer when oValid && iReady on a clock edge.
REQ-014 Decode: index k < WIDTH -> oData bit k = 1, all other bits 0, oErr = 0.
REQ-015 Index k >= WIDTH (only possible when WIDTH is not a power of 2) -> oData all zeros, oErr = 1; the beat is forwarded, not dropped.
REQ-016 Latency: an accepted beat appears on oData/oErr with oValid = 1 on the cycle after acceptance, when the output stage is empty or draining in that cycle.
REQ-017 Storage: one output register plus one skid register; total capacity 2 beats; beat order preserved.
REQ-018 oReady is registered and depends only on state: oReady = 1 iff the skid register is empty; no combinational path from iReady to oReady.
REQ-019 When the output register is held (oValid && !iReady) and a beat is accepted, that beat goes to the skid register; oReady drops on the next cycle.
REQ-020 On an output transfer with the skid register full, the skid register moves to the output register in the same edge; the skid register becomes empty and oReady returns to 1 on the next cycle.
REQ-021 Simultaneous input and output transfer with the skid register empty: the output register loads the new beat and oValid stays 1, giving full throughput of 1 beat/cycle.
REQ-022 oData/oErr are stable while oValid && !iReady.
REQ-023 oErrCount increments by 1 at input acceptance of an out-of-range index; it holds at 2^CNT_WIDTH-1 (no wrap).
REQ-024 iData is ignored when iValid = 0 or oReady = 0.

Reset
REQ-025 While iRst = 1 at an edge: oValid = 0, oData = 0, oErr = 0, oErrCount = 0, oReady = 0, skid register empty; no input is accepted.
REQ-026 First edge with iRst = 0: oReady = 1 on the following cycle.
REQ-027 Reset mid-operation discards all buffered beats; no partial beat is emitted afterwards.

Verification
REQ-028 WIDTH=32, iReady=1, indices 0, 5, 31 on consecutive cycles -> oData = 0x00000001, 0x00000020, 0x80000000 on the 3 following cycles, oValid continuous, oErr=0.
REQ-029 WIDTH=12, index 13 then 11 -> oData=0x000 with oErr=1, then 0x800 with oErr=0; oErrCount=1.
REQ-030 WIDTH=32, iReady=0, send indices 3, 4 -> oReady=0 after second accept, oData holds 0x00000008; raise iReady -> 0x00000008 then 0x00000010 transferred, oReady back to 1.
REQ-031 WIDTH=12, CNT_WIDTH=2, 5 out-of-range beats -> oErrCount 1, 2, 3, 3, 3.
REQ-032 Two beats buffered with iReady=0, assert iRst for 1 cycle -> oValid=0, oErrCount=0; no stale beat after reset release; oReady=1 one cycle after release.
REQ-033 Random iValid/iReady for 10k cycles, WIDTH=12 -> output sequence equals input sequence decoded, each oData has popcount 1 (or 0 with oErr=1), no loss or duplication.
